main_control_fsm: RTL and testbench
===================================

Name: main_control_fsm

Overview:
- Multi-cycle MIPS main control unit: sequences each instruction through fetch, decode, execute, memory and writeback states.
- Produces the 2-bit ALUOp consumed by the ALU control decoder, plus all datapath mux selects and write enables.
- Stalls on a memory ready handshake and flags memory timeouts.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles spent waiting for mem_ready in a memory state before abort (range 1-255).
- CNT_W, 8: width of the wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  6  instr[31:26] from the instruction register.
- zero  in  1  ALU zero flag; used externally with branch/branch_ne, ignored internally.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- pc_write  out  1  unconditional PC load.
- branch  out  1  beq PC-load qualifier.
- branch_ne  out  1  bne PC-load qualifier.
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
- alu_op  out  2  00 = add, 01 = subtract/compare, 10 = funct-decoded.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUOut, 1 = memory data register.
- reg_write  out  1  register file write enable.
- mem_err  out  1  one-cycle pulse when a memory wait times out.
- illegal  out  1  one-cycle pulse in DECODE when the opcode is unrecognised.

Behaviour:
- State register and wait counter reset asynchronously when rst = 0: state = S_RESET, counter = 0.
- In S_RESET every output is 0. The first rising edge with rst = 1 moves to FETCH.
- Outputs are decoded from the state, except the mem_ready gating noted below. Any signal not listed for a state is 0.
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write = pc_write = mem_ready. Advance to DECODE on mem_ready.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXECUTE
  - 000100 (beq) or 000101 (bne) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other opcode -> FETCH, with illegal pulsed.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: iord=1. Wait for mem_ready, then MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Next: FETCH.
- MEMWRITE: iord=1, mem_write=1, held until mem_ready. Next: FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01. branch=1 for beq, branch_ne=1 for bne; the opcode is held stable by the IR. Next: FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDIWB.
- ADDIWB: reg_dst=0, reg_write=1. Next: FETCH.
- JUMP: pc_src=10, pc_write=1. Next: FETCH.
- Latency with mem_ready tied high: lw 5 cycles; sw, R-type and addi 4; beq, bne and j 3.
- Wait counter:
  - Increments each cycle in FETCH, MEMREAD or MEMWRITE while mem_ready = 0.
  - Clears on every state change.
  - When counter == MEM_TIMEOUT-1 and mem_ready = 0: pulse mem_err and go to FETCH.
  - An aborted FETCH never asserts ir_write or pc_write.
  - mem_ready = 1 on the timeout cycle takes priority: normal advance, no mem_err.
- Reset asserted mid-instruction returns to S_RESET immediately and forces all outputs to 0.

Optional Feature:
- ILLEGAL_TRAP_EN
- Defined: an unrecognised opcode in DECODE goes to TRAP instead of FETCH.
  - TRAP holds all enables at 0 and illegal = 1 continuously.
  - Only reset leaves TRAP.
- Undefined: TRAP does not exist; illegal pulses for one cycle and the FSM returns to FETCH.

Test Plan:
- Reset then lw (opcode 100011), mem_ready=1 -> state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write=1 and mem_to_reg=1 only in cycle 5.
- R-type (000000) -> alu_op=10 in EXECUTE. reg_dst=1 and reg_write=1 in the next cycle. Back in FETCH on cycle 5.
- beq then bne -> BRANCH with alu_op=01 and pc_src=01; branch=1 for beq, branch_ne=1 for bne, never both.
- sw with mem_ready held low for 3 cycles -> mem_write=1 for 4 cycles, then FETCH, no mem_err.
- FETCH with mem_ready held low, MEM_TIMEOUT=15 -> mem_err pulses on the 15th cycle, ir_write never asserts, FETCH re-entered with counter 0.
- Opcode 111111 -> illegal pulses in DECODE and the FSM returns to FETCH. With ILLEGAL_TRAP_EN: illegal stays high, all enables 0, until rst=0.

Source files
------------

// File: rtl/main_control_fsm.sv
// Multi-cycle MIPS main control unit.
// Steps each instruction through fetch, decode, execute, memory and writeback.
// Stalls on mem_ready and aborts a memory wait after MEM_TIMEOUT cycles.
// Optional build macro ILLEGAL_TRAP_EN: an unknown opcode parks the FSM in TRAP
// until reset, instead of returning to FETCH.
module main_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic       branch_ne,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       mem_err,
    output logic       illegal
);

    localparam logic [3:0] S_RESET    = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEMADR   = 4'd3;
    localparam logic [3:0] S_MEMREAD  = 4'd4;
    localparam logic [3:0] S_MEMWB    = 4'd5;
    localparam logic [3:0] S_MEMWRITE = 4'd6;
    localparam logic [3:0] S_EXECUTE  = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_ADDIEX   = 4'd10;
    localparam logic [3:0] S_ADDIWB   = 4'd11;
    localparam logic [3:0] S_JUMP     = 4'd12;
`ifdef ILLEGAL_TRAP_EN
    localparam logic [3:0] S_TRAP     = 4'd13;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             waiting;
    logic             timeout;

    // zero only qualifies branch/branch_ne outside this block
    logic unused_zero;
    assign unused_zero = zero;

    // A memory-facing state that has not yet seen mem_ready
    assign waiting = ((state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE))
                     && !mem_ready;
    assign timeout = waiting && (cnt_q == CNT_LIMIT);

    // State and wait-counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state selection; a timeout overrides the normal stall
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:    state_d = S_FETCH;
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:    state_d = S_MEMADR;
                    OP_RTYPE:        state_d = S_EXECUTE;
                    OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                    OP_ADDI:         state_d = S_ADDIEX;
                    OP_J:            state_d = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
                    default:         state_d = S_TRAP;
`else
                    default:         state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_ADDIEX:   state_d = S_ADDIWB;
            S_ADDIWB:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_RESET;
        endcase
        if (timeout) state_d = S_FETCH;
    end

    // Wait counter clears on any state change or abort (abort of FETCH re-enters FETCH)
    always_comb begin
        cnt_d = cnt_q;
        if (timeout || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (waiting) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Output decode from state, with mem_ready gating in FETCH
    always_comb begin
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        mem_err    = timeout;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                illegal   = !((opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_RTYPE) ||
                              (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                              (opcode == OP_ADDI) || (opcode == OP_J));
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMREAD:  iord = 1'b1;
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch    = (opcode == OP_BEQ);
                branch_ne = (opcode == OP_BNE);
            end
            S_ADDIWB:   reg_write = 1'b1;
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:     illegal = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm: a per-cycle vector table for each
// opcode class plus hand-written stall, timeout and reset sequences.
module tb_main_control_fsm;

    localparam int unsigned TO = 15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       iord, mem_write, ir_write, pc_write, branch, branch_ne;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic       alu_src_a, reg_dst, mem_to_reg, reg_write, mem_err, illegal;

    main_control_fsm #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .branch     (branch),
        .branch_ne  (branch_ne),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .mem_err    (mem_err),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    logic [17:0] act;
    assign act = {iord, mem_write, ir_write, pc_write, branch, branch_ne, pc_src, alu_src_a,
                  alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, mem_err, illegal};

    typedef struct {
        logic [17:0] exp;
        string       tag;
    } exp_t;

    typedef struct {
        logic [5:0]  opc;
        logic        rdy;
        logic [17:0] exp;
        string       tag;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_total = 0;
    int   n_bad   = 0;

    function automatic logic [17:0] mk(input logic i_iord, input logic i_mw, input logic i_irw,
                                       input logic i_pcw, input logic i_br, input logic i_bne,
                                       input logic [1:0] i_pcs, input logic i_asa,
                                       input logic [1:0] i_asb, input logic [1:0] i_aop,
                                       input logic i_rd, input logic i_m2r, input logic i_rw,
                                       input logic i_err, input logic i_ill);
        return {i_iord, i_mw, i_irw, i_pcw, i_br, i_bne, i_pcs, i_asa, i_asb, i_aop,
                i_rd, i_m2r, i_rw, i_err, i_ill};
    endfunction

    logic [17:0] E_ZERO, E_FETCH_R, E_FETCH_W, E_FETCH_TO, E_DECODE, E_DECODE_ILL;
    logic [17:0] E_MEMADR, E_MEMREAD, E_MEMREAD_TO, E_MEMWB, E_MEMWRITE, E_EXECUTE;
    logic [17:0] E_ALUWB, E_BEQ, E_BNE, E_ADDIEX, E_ADDIWB, E_JUMP, E_TRAP;

    task automatic check_out();
        exp_t x;
        n_total++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: got %b, no expected entry", act);
        end else begin
            x = sb.pop_front();
            if (act !== x.exp) begin
                n_bad++;
                $display("FAIL %s: got %b required %b", x.tag, act, x.exp);
            end
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, compare on the falling edge
    task automatic step(input logic [5:0] opc, input logic rdy, input logic [17:0] e,
                        input string tag);
        exp_t x;
        opcode    = opc;
        mem_ready = rdy;
        x.exp     = e;
        x.tag     = tag;
        sb.push_back(x);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(OP_RTYPE, 1'b1, E_ZERO, "reset_hold");
        rst = 1'b1;
        step(OP_RTYPE, 1'b1, E_ZERO, "reset_release");
    endtask

    function automatic void add(input logic [5:0] opc, input logic rdy, input logic [17:0] e,
                                input string tag);
        vec_t v;
        v.opc = opc;
        v.rdy = rdy;
        v.exp = e;
        v.tag = tag;
        tbl.push_back(v);
    endfunction

    initial begin
        rst       = 1'b1;
        opcode    = OP_RTYPE;
        zero      = 1'b0;
        mem_ready = 1'b0;

        E_ZERO       = '0;
        E_FETCH_R    = mk(0, 0, 1, 1, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0);
        E_FETCH_W    = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0);
        E_FETCH_TO   = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0, 0, 0, 1, 0);
        E_DECODE     = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0);
        E_DECODE_ILL = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 2'b00, 0, 0, 0, 0, 1);
        E_MEMADR     = mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0);
        E_MEMREAD    = mk(1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        E_MEMREAD_TO = mk(1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0);
        E_MEMWB      = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 1, 1, 0, 0);
        E_MEMWRITE   = mk(1, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        E_EXECUTE    = mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b10, 0, 0, 0, 0, 0);
        E_ALUWB      = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 1, 0, 0);
        E_BEQ        = mk(0, 0, 0, 0, 1, 0, 2'b01, 1, 2'b00, 2'b01, 0, 0, 0, 0, 0);
        E_BNE        = mk(0, 0, 0, 0, 0, 1, 2'b01, 1, 2'b00, 2'b01, 0, 0, 0, 0, 0);
        E_ADDIEX     = mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0);
        E_ADDIWB     = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0);
        E_JUMP       = mk(0, 0, 0, 1, 0, 0, 2'b10, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        E_TRAP       = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1);

        // One row per cycle, mem_ready high throughout
        add(OP_LW,    1, E_FETCH_R,    "lw_fetch");
        add(OP_LW,    1, E_DECODE,     "lw_decode");
        add(OP_LW,    1, E_MEMADR,     "lw_memadr");
        add(OP_LW,    1, E_MEMREAD,    "lw_memread");
        add(OP_LW,    1, E_MEMWB,      "lw_memwb");
        add(OP_RTYPE, 1, E_FETCH_R,    "r_fetch");
        add(OP_RTYPE, 1, E_DECODE,     "r_decode");
        add(OP_RTYPE, 1, E_EXECUTE,    "r_execute");
        add(OP_RTYPE, 1, E_ALUWB,      "r_aluwb");
        add(OP_BEQ,   1, E_FETCH_R,    "beq_fetch");
        add(OP_BEQ,   1, E_DECODE,     "beq_decode");
        add(OP_BEQ,   1, E_BEQ,        "beq_branch");
        add(OP_BNE,   1, E_FETCH_R,    "bne_fetch");
        add(OP_BNE,   1, E_DECODE,     "bne_decode");
        add(OP_BNE,   1, E_BNE,        "bne_branch");
        add(OP_J,     1, E_FETCH_R,    "j_fetch");
        add(OP_J,     1, E_DECODE,     "j_decode");
        add(OP_J,     1, E_JUMP,       "j_jump");
        add(OP_ADDI,  1, E_FETCH_R,    "addi_fetch");
        add(OP_ADDI,  1, E_DECODE,     "addi_decode");
        add(OP_ADDI,  1, E_ADDIEX,     "addi_ex");
        add(OP_ADDI,  1, E_ADDIWB,     "addi_wb");
        add(OP_SW,    1, E_FETCH_R,    "sw_fetch");
        add(OP_SW,    1, E_DECODE,     "sw_decode");
        add(OP_SW,    1, E_MEMADR,     "sw_memadr");
        add(OP_SW,    1, E_MEMWRITE,   "sw_memwrite");
        add(OP_BAD,   1, E_FETCH_R,    "bad_fetch");
        add(OP_BAD,   1, E_DECODE_ILL, "bad_decode");

        #1;
        do_reset();
        foreach (tbl[i]) step(tbl[i].opc, tbl[i].rdy, tbl[i].exp, tbl[i].tag);

`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 4; i++) step(OP_LW, 1'b1, E_TRAP, "trap_hold");
        do_reset();
`endif

        // sw with three stalled write cycles
        step(OP_SW, 1'b1, E_FETCH_R,  "sws_fetch");
        step(OP_SW, 1'b1, E_DECODE,   "sws_decode");
        step(OP_SW, 1'b1, E_MEMADR,   "sws_memadr");
        for (int i = 0; i < 3; i++) step(OP_SW, 1'b0, E_MEMWRITE, "sws_stall");
        step(OP_SW, 1'b1, E_MEMWRITE, "sws_done");

        // FETCH timeout, then a full-length wait finishing on the limit cycle
        for (int i = 0; i < int'(TO) - 1; i++) step(OP_J, 1'b0, E_FETCH_W, "fetch_wait");
        step(OP_J, 1'b0, E_FETCH_TO, "fetch_timeout");
        for (int i = 0; i < int'(TO) - 1; i++) step(OP_J, 1'b0, E_FETCH_W, "fetch_rewait");
        step(OP_J, 1'b1, E_FETCH_R, "fetch_ready_at_limit");
        step(OP_J, 1'b1, E_DECODE,  "fetch_after_limit_decode");
        step(OP_J, 1'b1, E_JUMP,    "fetch_after_limit_jump");

        // MEMREAD timeout aborts back to FETCH
        step(OP_LW, 1'b1, E_FETCH_R, "lwt_fetch");
        step(OP_LW, 1'b1, E_DECODE,  "lwt_decode");
        step(OP_LW, 1'b0, E_MEMADR,  "lwt_memadr");
        for (int i = 0; i < int'(TO) - 1; i++) step(OP_LW, 1'b0, E_MEMREAD, "lwt_wait");
        step(OP_LW, 1'b0, E_MEMREAD_TO, "lwt_timeout");
        step(OP_LW, 1'b1, E_FETCH_R,    "lwt_refetch");

        // Reset in the middle of an R-type instruction
        step(OP_RTYPE, 1'b1, E_DECODE,  "mid_decode");
        step(OP_RTYPE, 1'b1, E_EXECUTE, "mid_execute");
        do_reset();
        step(OP_RTYPE, 1'b1, E_FETCH_R, "post_reset_fetch");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
